card_store: RTL and testbench

Parametrised card-state register file for the memory game. It holds one entry per card:
- active flag
- discovered flag
- COLOR_W-bit colour

It adds, on top of the plain register file:
- two read ports, so both flipped cards can be looked up together
- a registered colour-match flag
- live counts of active and discovered cards
- a bulk sweep engine that covers or clears every card without the game controller addressing them one by one

It sits between the game control FSM (writer, commander) and the draw/compare logic (readers).

---
 rtl/card_pkg.sv | 21 ++
 rtl/card_sweep_ctrl.sv | 72 +++++++
 rtl/card_store.sv | 125 ++++++++++++
 tb/tb_card_store.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/card_pkg.sv
// Shared encodings for the card-state store: entry bit layout, write modes,
// bulk command opcodes and the sweep FSM state type.
package card_pkg;

  localparam int ACTIVE_BIT = 0;
  localparam int DISC_BIT   = 1;
  localparam int COLOR_LSB  = 2;

  localparam logic [1:0] WM_NONE  = 2'b00;
  localparam logic [1:0] WM_FULL  = 2'b01;
  localparam logic [1:0] WM_FLAGS = 2'b10;

  localparam logic OP_COVER_ALL = 1'b0;
  localparam logic OP_CLEAR_ALL = 1'b1;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SWEEP = 1'b1
  } sweep_state_t;

endpackage

// File: rtl/card_sweep_ctrl.sv
// Bulk sweep sequencer: walks an index over every card entry, one per cycle,
// and reports busy / a single-cycle done pulse.
module card_sweep_ctrl
  import card_pkg::*;
#(
  parameter int N_CARDS = 12,
  parameter int ADDR_W  = $clog2(N_CARDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  input  logic              cmd_op,
  output logic              cmd_ready,
  output logic              busy,
  output logic              done,
  output logic              sweep_en,
  output logic [ADDR_W-1:0] sweep_idx,
  output logic              sweep_op
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_CARDS - 1);

  sweep_state_t      state, state_next;
  logic [ADDR_W-1:0] idx_next;
  logic              op_next;
  logic              done_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      sweep_idx <= '0;
      sweep_op  <= OP_COVER_ALL;
      done      <= 1'b0;
    end else begin
      state     <= state_next;
      sweep_idx <= idx_next;
      sweep_op  <= op_next;
      done      <= done_next;
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = sweep_idx;
    op_next    = sweep_op;
    done_next  = 1'b0;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          state_next = S_SWEEP;
          idx_next   = '0;
          op_next    = cmd_op;
        end
      end
      S_SWEEP: begin
        // done is registered so it lands in the first idle cycle
        if (sweep_idx == LAST_IDX) begin
          state_next = S_IDLE;
          done_next  = 1'b1;
        end else begin
          idx_next = sweep_idx + ADDR_W'(1);
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign busy      = (state == S_SWEEP);
  assign cmd_ready = ~busy;
  assign sweep_en  = busy;

endmodule

// File: rtl/card_store.sv
// Card-state register file: dual combinational read ports, registered colour
// match, incremental active/discovered counters and a bulk sweep engine.
module card_store
  import card_pkg::*;
#(
  parameter int N_CARDS = 12,
  parameter int COLOR_W = 12,
  parameter int ADDR_W  = $clog2(N_CARDS),
  parameter int CNT_W   = $clog2(N_CARDS + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           w_mode,
  input  logic [ADDR_W-1:0]    w_address,
  input  logic [COLOR_W+1:0]   w_data,
  input  logic [ADDR_W-1:0]    r_address_a,
  input  logic [ADDR_W-1:0]    r_address_b,
  output logic [COLOR_W+1:0]   r_data_a,
  output logic [COLOR_W+1:0]   r_data_b,
  output logic                 match_ab,
  input  logic                 cmd_valid,
  input  logic                 cmd_op,
  output logic                 cmd_ready,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     active_count,
  output logic [CNT_W-1:0]     discovered_count
);

  localparam int ENTRY_W = COLOR_W + 2;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return 32'(a) < N_CARDS;
  endfunction

  logic [ENTRY_W-1:0] entries [N_CARDS];

  logic              sweep_en;
  logic [ADDR_W-1:0] sweep_idx;
  logic              sweep_op;

  card_sweep_ctrl #(.N_CARDS(N_CARDS), .ADDR_W(ADDR_W)) u_sweep (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_op    (cmd_op),
    .cmd_ready (cmd_ready),
    .busy      (busy),
    .done      (done),
    .sweep_en  (sweep_en),
    .sweep_idx (sweep_idx),
    .sweep_op  (sweep_op)
  );

  // At most one entry changes per cycle: sweep and writes are mutually exclusive
  logic               touch_en;
  logic [ADDR_W-1:0]  touch_idx;
  logic [ENTRY_W-1:0] touch_old;
  logic [ENTRY_W-1:0] touch_new;

  always_comb begin
    touch_en  = 1'b0;
    touch_idx = '0;
    touch_old = '0;
    touch_new = '0;
    if (sweep_en) begin
      touch_en  = 1'b1;
      touch_idx = sweep_idx;
      touch_old = entries[sweep_idx];
      if (sweep_op == OP_CLEAR_ALL) begin
        touch_new = '0;
      end else begin
        touch_new           = touch_old;
        touch_new[DISC_BIT] = 1'b0;
      end
    end else if (in_range(w_address)) begin
      touch_idx = w_address;
      touch_old = entries[w_address];
      case (w_mode)
        WM_FULL: begin
          touch_en  = 1'b1;
          touch_new = w_data;
        end
        WM_FLAGS: begin
          touch_en  = 1'b1;
          touch_new = {touch_old[ENTRY_W-1:COLOR_LSB], w_data[DISC_BIT:ACTIVE_BIT]};
        end
        WM_NONE: touch_en = 1'b0;
        default: touch_en = 1'b0;
      endcase
    end
  end

  assign r_data_a = in_range(r_address_a) ? entries[r_address_a] : '0;
  assign r_data_b = in_range(r_address_b) ? entries[r_address_b] : '0;

  logic match_next;
  assign match_next = in_range(r_address_a) && in_range(r_address_b) &&
                      (r_address_a != r_address_b) &&
                      r_data_a[ACTIVE_BIT] && r_data_b[ACTIVE_BIT] &&
                      (r_data_a[ENTRY_W-1:COLOR_LSB] == r_data_b[ENTRY_W-1:COLOR_LSB]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CARDS; i++) entries[i] <= '0;
      active_count     <= '0;
      discovered_count <= '0;
      match_ab         <= 1'b0;
    end else begin
      match_ab <= match_next;
      if (touch_en) begin
        entries[touch_idx] <= touch_new;
        if (touch_new[ACTIVE_BIT] && !touch_old[ACTIVE_BIT])
          active_count <= active_count + CNT_W'(1);
        else if (!touch_new[ACTIVE_BIT] && touch_old[ACTIVE_BIT])
          active_count <= active_count - CNT_W'(1);
        if (touch_new[DISC_BIT] && !touch_old[DISC_BIT])
          discovered_count <= discovered_count + CNT_W'(1);
        else if (!touch_new[DISC_BIT] && touch_old[DISC_BIT])
          discovered_count <= discovered_count - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_card_store.sv
// Directed bench for card_store: writes, reads, match flag, sweeps and reset abort.
module tb_card_store;
  import card_pkg::*;

  localparam int N = 12;
  localparam int CW = 12;
  localparam int AW = 4;
  localparam int NW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    w_mode;
  logic [AW-1:0] w_address;
  logic [CW+1:0] w_data;
  logic [AW-1:0] r_address_a, r_address_b;
  logic [CW+1:0] r_data_a, r_data_b;
  logic          match_ab;
  logic          cmd_valid, cmd_op;
  logic          cmd_ready, busy, done;
  logic [NW-1:0] active_count, discovered_count;

  int vectors = 0;
  int miscompares = 0;

  card_store #(.N_CARDS(N), .COLOR_W(CW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .w_mode           (w_mode),
    .w_address        (w_address),
    .w_data           (w_data),
    .r_address_a      (r_address_a),
    .r_address_b      (r_address_b),
    .r_data_a         (r_data_a),
    .r_data_b         (r_data_b),
    .match_ab         (match_ab),
    .cmd_valid        (cmd_valid),
    .cmd_op           (cmd_op),
    .cmd_ready        (cmd_ready),
    .busy             (busy),
    .done             (done),
    .active_count     (active_count),
    .discovered_count (discovered_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] m, input logic [AW-1:0] a, input logic [CW+1:0] d);
    w_mode = m; w_address = a; w_data = d;
    step();
    w_mode = WM_NONE;
  endtask

  task automatic rd_check(input string tag, input logic [AW-1:0] a, input logic [CW+1:0] exp);
    r_address_a = a;
    #1;
    check(tag, 32'(r_data_a), 32'(exp));
  endtask

  task automatic wait_idle(output int n, output int pulses);
    n = 0; pulses = 0;
    while (busy && n < 40) begin
      step();
      n++;
      if (busy && done) pulses++;
    end
  endtask

  task automatic issue(input logic op);
    cmd_valid = 1'b1; cmd_op = op;
    step();
    cmd_valid = 1'b0;
  endtask

  int n, pulses, dseen;

  initial begin
    rst_n = 1'b1; w_mode = WM_NONE; w_address = '0; w_data = '0;
    r_address_a = '0; r_address_b = '0; cmd_valid = 1'b0; cmd_op = 1'b0;
    #2 rst_n = 1'b0;
    step(); step();
    check("rst_rdata_a", 32'(r_data_a), 0);
    check("rst_rdata_b", 32'(r_data_b), 0);
    check("rst_act", 32'(active_count), 0);
    check("rst_disc", 32'(discovered_count), 0);
    check("rst_ready", 32'(cmd_ready), 1);
    check("rst_busy_done_match", {29'd0, busy, done, match_ab}, 0);
    rst_n = 1'b1;
    step();

    // full write and flags-only write
    wr(WM_FULL, 4'd3, {12'hF00, 2'b01});
    rd_check("wr3", 4'd3, 14'h3C01);
    check("wr3_act", 32'(active_count), 1);
    wr(WM_FULL, 4'd5, {12'hF00, 2'b11});
    rd_check("wr5", 4'd5, 14'h3C03);
    check("wr5_disc", 32'(discovered_count), 1);
    wr(WM_FLAGS, 4'd5, {12'h0FF, 2'b01});
    rd_check("flags5", 4'd5, 14'h3C01);
    check("flags5_disc", 32'(discovered_count), 0);
    check("flags5_act", 32'(active_count), 2);

    // match flag
    r_address_a = 4'd3; r_address_b = 4'd5;
    step();
    check("match_35", 32'(match_ab), 1);
    r_address_b = 4'd3;
    step();
    check("match_same", 32'(match_ab), 0);
    r_address_b = 4'd5;
    step();
    check("match_35_again", 32'(match_ab), 1);
    wr(WM_FLAGS, 4'd5, {12'h000, 2'b00});
    step();
    check("match_inactive", 32'(match_ab), 0);
    r_address_b = 4'd12;
    wr(WM_FLAGS, 4'd5, {12'h000, 2'b01});
    step();
    check("match_oor", 32'(match_ab), 0);
    check("react_act", 32'(active_count), 2);

    // four discovered cards, then COVER_ALL with a dropped mid-sweep write
    wr(WM_FULL, 4'd0, {12'h001, 2'b11});
    wr(WM_FULL, 4'd1, {12'h002, 2'b11});
    wr(WM_FULL, 4'd2, {12'h003, 2'b11});
    wr(WM_FULL, 4'd4, {12'h004, 2'b11});
    check("pre_cover_act", 32'(active_count), 6);
    check("pre_cover_disc", 32'(discovered_count), 4);
    issue(OP_COVER_ALL);
    check("cover_busy", 32'(busy), 1);
    check("cover_notready", 32'(cmd_ready), 0);
    n = 0; dseen = 0;
    while (busy && n < 40) begin
      if (n == 3) begin w_mode = WM_FULL; w_address = 4'd11; w_data = 14'h3FFF; end
      step();
      w_mode = WM_NONE;
      n++;
      if (busy && done) dseen++;
    end
    check("cover_cycles", 32'(n), 12);
    check("cover_done", 32'(done), 1);
    check("cover_ready", 32'(cmd_ready), 1);
    check("cover_no_early_done", 32'(dseen), 0);
    step();
    check("cover_done_pulse", 32'(done), 0);
    check("cover_disc", 32'(discovered_count), 0);
    check("cover_act", 32'(active_count), 6);
    rd_check("cover_e0", 4'd0, 14'h0005);
    rd_check("cover_e4", 4'd4, 14'h0011);
    rd_check("cover_e3", 4'd3, 14'h3C01);
    rd_check("cover_e11_dropped", 4'd11, 14'h0000);

    // fill all, COVER with same-cycle write, back-to-back CLEAR_ALL
    for (int i = 0; i < N; i++) wr(WM_FULL, AW'(i), {12'(i * 17), 2'b11});
    check("fill_act", 32'(active_count), 12);
    check("fill_disc", 32'(discovered_count), 12);
    w_mode = WM_FULL; w_address = 4'd0; w_data = {12'hABC, 2'b11};
    issue(OP_COVER_ALL);
    w_mode = WM_NONE;
    wait_idle(n, pulses);
    check("cover2_done", 32'(done), 1);
    check("cover2_disc", 32'(discovered_count), 0);
    check("cover2_act", 32'(active_count), 12);
    rd_check("cover2_e0_sameedge", 4'd0, 14'h2AF1);
    issue(OP_CLEAR_ALL);
    check("b2b_accept", 32'(busy), 1);
    wait_idle(n, pulses);
    check("clear_cycles", 32'(n), 12);
    check("clear_done", 32'(done), 1);
    check("clear_act", 32'(active_count), 0);
    check("clear_disc", 32'(discovered_count), 0);
    rd_check("clear_e0", 4'd0, 14'h0000);
    rd_check("clear_e7", 4'd7, 14'h0000);
    rd_check("clear_e11", 4'd11, 14'h0000);
    wr(WM_FULL, 4'd12, {12'hFFF, 2'b11});
    check("oor_wr_act", 32'(active_count), 0);
    rd_check("oor_rd15", 4'd15, 14'h0000);
    rd_check("oor_rd12", 4'd12, 14'h0000);

    // reset in the middle of a sweep
    wr(WM_FULL, 4'd2, {12'h123, 2'b11});
    check("pre_abort_act", 32'(active_count), 1);
    issue(OP_COVER_ALL);
    step(); step(); step(); step();
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 0);
    check("abort_ready", 32'(cmd_ready), 1);
    check("abort_act", 32'(active_count), 0);
    check("abort_disc", 32'(discovered_count), 0);
    rd_check("abort_e2", 4'd2, 14'h0000);
    dseen = 0;
    for (int i = 0; i < 3; i++) begin step(); if (done) dseen++; end
    rst_n = 1'b1;
    for (int i = 0; i < 14; i++) begin step(); if (done) dseen++; end
    check("abort_no_done", 32'(dseen), 0);
    wr(WM_FULL, 4'd2, {12'h123, 2'b11});
    issue(OP_CLEAR_ALL);
    wait_idle(n, pulses);
    check("post_abort_cycles", 32'(n), 12);
    check("post_abort_done", 32'(done), 1);
    check("post_abort_act", 32'(active_count), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
